rf_access_ctrl: RTL and testbench

Request/response front-end that owns the single port of the CPU register file. It accepts read and write commands from the control unit over a valid/ready handshake and drives the file's write-enable, address and write data. It captures the file's registered read data and returns it on a held response channel. It also provides a hardware clear sequence that zeroes every entry without control-unit involvement.

---
 rtl/rf_access_ctrl_pkg.sv | 17 +
 rtl/rf_access_ctrl_if.sv | 26 ++
 rtl/rf_access_ctrl_regfile.sv | 37 +++
 rtl/rf_access_ctrl.sv | 116 +++++++++++
 tb/tb_rf_access_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_access_ctrl_pkg.sv
// Shared CPU register-file constants and the access controller state type.
package cpu_pkg;

  localparam int RF_DEPTH  = 8;
  localparam int RF_ADDR_W = 3;
  localparam int RF_DATA_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_RSP     = 3'd4,
    ST_CLEAR   = 3'd5
  } rf_ctrl_state_t;

endpackage

// File: rtl/rf_access_ctrl_if.sv
// Command/response channel between the control unit (master) and rf_access_ctrl (slave).
interface rf_access_ctrl_if #(
  parameter int ADDR_W = cpu_pkg::RF_ADDR_W,
  parameter int DATA_W = cpu_pkg::RF_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rf_access_ctrl_regfile.sv
// Single-port register file: synchronous write, registered read-before-write output.
// One cycle read latency; no backpressure. Contents are not touched by reset.
module rf_access_ctrl_regfile
  import cpu_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rf_access_ctrl.sv
// Owns the register-file port: serialises read/write commands and runs a clear-all sweep.
// Write 2 cycles, read response after 2 cycles held until rsp_ready; req_ready only in IDLE.
module rf_access_ctrl
  import cpu_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  rf_access_ctrl_if.slave   bus,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
  localparam logic [2:0] S_WR      = 3'(ST_WR);
  localparam logic [2:0] S_RD_ADDR = 3'(ST_RD_ADDR);
  localparam logic [2:0] S_RD_DATA = 3'(ST_RD_DATA);
  localparam logic [2:0] S_RSP     = 3'(ST_RSP);
  localparam logic [2:0] S_CLEAR   = 3'(ST_CLEAR);

  logic [2:0]        r_state;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_clr_busy;
  logic              w_clr_last;

  assign w_clr_last = (r_addr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_en     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_clr_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clr_start) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wr_en    <= 1'b1;
            r_clr_busy <= 1'b1;
            r_state    <= S_CLEAR;
          end else if (bus.req_valid) begin
            r_addr <= bus.req_addr;
            if (bus.req_write) begin
              r_wdata <= bus.req_wdata;
              r_wr_en <= 1'b1;
              r_state <= S_WR;
            end else begin
              r_wr_en <= 1'b0;
              r_state <= S_RD_ADDR;
            end
          end
        end
        S_WR: begin
          r_wr_en <= 1'b0;
          r_state <= S_IDLE;
        end
        S_RD_ADDR: begin
          r_state <= S_RD_DATA;
        end
        // File output now reflects the address presented in RD_ADDR.
        S_RD_DATA: begin
          r_rsp_data  <= rf_rdata;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
        end
        S_RSP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_CLEAR: begin
          if (w_clr_last) begin
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_clr_busy <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        default: begin
          r_wr_en     <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_clr_busy  <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign clr_busy      = r_clr_busy;
  assign rf_wr_en      = r_wr_en;
  assign rf_addr       = r_addr;
  assign rf_wdata      = r_wdata;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Self-checking bench: rf_access_ctrl driving the register file, checked against an array model.
module tb_rf_access_ctrl;
  import cpu_pkg::*;

  localparam int DEPTH = RF_DEPTH;
  localparam int AW    = RF_ADDR_W;
  localparam int DW    = RF_DATA_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rst_n;
  logic          clr_start = 1'b0;
  logic          clr_busy;
  logic          rf_wr_en;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] ref_mem [DEPTH];

  rf_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  assign rst_n = ~rst;

  rf_access_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .rf_wr_en  (rf_wr_en),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata)
  );

  rf_access_ctrl_regfile #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr_en (rf_wr_en),
    .i_addr  (rf_addr),
    .i_wdata (rf_wdata),
    .o_rdata (rf_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL wait_ready: req_ready=%b required 1 within 40 cycles", bus.req_ready);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    tick();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    tick();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    d = bus.rsp_data;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({rf_wr_en, rf_addr, rf_wdata, bus.rsp_valid, bus.rsp_data, clr_busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: wr_en=%b addr=%0d wdata=%h rsp_valid=%b rsp_data=%h clr_busy=%b required all 0",
               rf_wr_en, rf_addr, rf_wdata, bus.rsp_valid, bus.rsp_data, clr_busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready: got %b required 1", bus.req_ready);
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d;
    int lat;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 3'd5;
    bus.req_wdata = 4'hA;
    tick();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    ref_mem[5] = 4'hA;
    checks++;
    if ({rf_wr_en, rf_addr, rf_wdata} !== {1'b1, 3'd5, 4'hA}) begin
      failures++;
      $display("FAIL write_drive: wr_en=%b addr=%0d wdata=%h required 1/5/a", rf_wr_en, rf_addr, rf_wdata);
    end
    tick();
    checks++;
    if ({rf_wr_en, bus.req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL write_one_cycle: wr_en=%b req_ready=%b required 0/1", rf_wr_en, bus.req_ready);
    end
    do_read(3'd5, d, lat);
    checks++;
    if (d !== ref_mem[5] || lat != 2) begin
      failures++;
      $display("FAIL read_after_write: data=%h lat=%0d required %h lat=2", d, lat, ref_mem[5]);
    end
  endtask

  task automatic test_rsp_stall();
    logic [DW-1:0] held;
    do_write(3'd2, DW'($urandom_range(0, 15)));
    wait_ready();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 3'd2;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    held = ref_mem[2];
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.req_ready} !== {1'b1, held, 1'b0}) begin
        failures++;
        $display("FAIL rsp_stall[%0d]: rsp_valid=%b rsp_data=%h req_ready=%b required 1/%h/0",
                 i, bus.rsp_valid, bus.rsp_data, bus.req_ready, held);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.req_ready, bus.rsp_data} !== {1'b0, 1'b1, held}) begin
      failures++;
      $display("FAIL rsp_release: rsp_valid=%b req_ready=%b rsp_data=%h required 0/1/%h",
               bus.rsp_valid, bus.req_ready, bus.rsp_data, held);
    end
  endtask

  task automatic test_clear();
    logic [DW-1:0] d;
    int lat;
    int n;
    for (int a = 0; a < DEPTH; a++) do_write(AW'(a), 4'hF);
    wait_ready();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 20) begin
      checks++;
      if ({rf_wr_en, rf_addr, rf_wdata, bus.req_ready} !== {1'b1, AW'(n), 4'h0, 1'b0}) begin
        failures++;
        $display("FAIL clear_step[%0d]: wr_en=%b addr=%0d wdata=%h req_ready=%b required 1/%0d/0/0",
                 n, rf_wr_en, rf_addr, rf_wdata, bus.req_ready, n);
      end
      n++;
      tick();
    end
    checks++;
    if (n != DEPTH || {bus.req_ready, rf_wr_en, rf_addr} !== {1'b1, 1'b0, AW'(0)}) begin
      failures++;
      $display("FAIL clear_length: busy cycles=%0d req_ready=%b wr_en=%b addr=%0d required %0d/1/0/0",
               n, bus.req_ready, rf_wr_en, rf_addr, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    for (int a = 0; a < DEPTH; a++) begin
      do_read(AW'(a), d, lat);
      checks++;
      if (d !== ref_mem[a] || lat != 2) begin
        failures++;
        $display("FAIL clear_readback[%0d]: data=%h lat=%0d required %h lat=2", a, d, lat, ref_mem[a]);
      end
    end
  endtask

  task automatic test_clr_priority();
    logic [DW-1:0] d;
    int lat;
    int n;
    for (int a = 0; a < DEPTH; a++) do_write(AW'(a), DW'($urandom_range(1, 15)));
    wait_ready();
    clr_start     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 3'd1;
    bus.req_wdata = 4'h3;
    tick();
    clr_start = 1'b0;
    checks++;
    if ({clr_busy, bus.req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL clr_priority: clr_busy=%b req_ready=%b required 1/0", clr_busy, bus.req_ready);
    end
    n = 0;
    while (clr_busy === 1'b1 && n < 20) begin
      checks++;
      if (rf_wdata !== 4'h0) begin
        failures++;
        $display("FAIL clr_priority_wdata[%0d]: wdata=%h required 0", n, rf_wdata);
      end
      n++;
      tick();
    end
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    checks++;
    if (n != DEPTH || {bus.req_ready, rf_wr_en} !== 2'b10) begin
      failures++;
      $display("FAIL clr_priority_end: busy cycles=%0d req_ready=%b wr_en=%b required %0d/1/0",
               n, bus.req_ready, rf_wr_en, DEPTH);
    end
    tick();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    ref_mem[1] = 4'h3;
    checks++;
    if ({rf_wr_en, rf_addr, rf_wdata} !== {1'b1, 3'd1, 4'h3}) begin
      failures++;
      $display("FAIL clr_priority_accept: wr_en=%b addr=%0d wdata=%h required 1/1/3", rf_wr_en, rf_addr, rf_wdata);
    end
    for (int a = 0; a < 3; a++) begin
      do_read(AW'(a), d, lat);
      checks++;
      if (d !== ref_mem[a]) begin
        failures++;
        $display("FAIL clr_priority_read[%0d]: data=%h required %h", a, d, ref_mem[a]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [DW-1:0] d;
    int lat;
    int n;
    for (int a = 0; a < DEPTH; a++) do_write(AW'(a), DW'($urandom_range(1, 15)));
    wait_ready();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (rf_addr !== 3'd3 && n < 20) begin
      tick();
      n++;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({rf_wr_en, rf_addr, rf_wdata, bus.rsp_valid, bus.rsp_data, clr_busy} !== '0 || n >= 20) begin
      failures++;
      $display("FAIL reset_mid_clear: wr_en=%b addr=%0d wdata=%h rsp_valid=%b clr_busy=%b steps=%0d required all 0",
               rf_wr_en, rf_addr, rf_wdata, bus.rsp_valid, clr_busy, n);
    end
    tick();
    rst = 1'b0;
    for (int a = 0; a < 3; a++) ref_mem[a] = '0;
    for (int a = 0; a < DEPTH; a++) begin
      do_read(AW'(a), d, lat);
      checks++;
      if (d !== ref_mem[a]) begin
        failures++;
        $display("FAIL partial_clear[%0d]: data=%h required %h", a, d, ref_mem[a]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    int lat;
    logic accepted;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = AW'($urandom_range(0, DEPTH - 1));
    bus.req_wdata = DW'($urandom_range(0, 15));
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({bus.req_ready, clr_busy} !== {((i % 2) == 0), 1'b0}) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: req_ready=%b clr_busy=%b required %b/0",
                 i, bus.req_ready, clr_busy, ((i % 2) == 0));
      end
      accepted = bus.req_ready;
      if (accepted) ref_mem[bus.req_addr] = bus.req_wdata;
      // clr_start pulsed while busy writing must be dropped
      clr_start = ~accepted;
      tick();
      if (accepted) begin
        bus.req_addr  = AW'($urandom_range(0, DEPTH - 1));
        bus.req_wdata = DW'($urandom_range(0, 15));
      end
    end
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    clr_start     = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      do_read(AW'(a), d, lat);
      checks++;
      if (d !== ref_mem[a]) begin
        failures++;
        $display("FAIL b2b_readback[%0d]: data=%h required %h", a, d, ref_mem[a]);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, DW'($urandom_range(0, 15)));
      end else begin
        do_read(a, d, lat);
        checks++;
        if (d !== ref_mem[a] || lat != 2) begin
          failures++;
          $display("FAIL random_read[%0d] addr %0d: data=%h lat=%0d required %h lat=2", i, a, d, lat, ref_mem[a]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    test_reset();
    test_write_read();
    test_rsp_stall();
    test_clear();
    test_clr_priority();
    test_reset_mid_clear();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
